// File: rtl/seg_page_sched.sv
// seg_page_sched
// ----------------------------------------------------------------------------
// Display-content scheduler for the 8-digit 7-segment scanner. It rotates
// between a TIME page and a DATE page on a second-based dwell. Handshaken
// one-shot messages preempt that rotation. When blinking is compiled in,
// selected digits blink during field editing.
//
// Optional feature: define SEG_PAGE_BLINK_EN to build the per-digit blink
// logic. When it is not defined, blink_mask is ignored and no blink logic is
// built.
//
// Ports:
//   seg_clk     in   1  system clock
//   seg_rst     in   1  asynchronous, active-high reset
//   time_bcd    in  32  time page content, 8 BCD nibbles ([31:28] = leftmost)
//   date_bcd    in  32  date page content, 8 BCD nibbles
//   hold_page   in   1  freeze dwell counting on TIME/DATE (edit mode)
//   blink_mask  in   8  per-digit blink enable, bit7 -> nibble[31:28]
//   msg_req     in   1  message request, level, held until msg_ack
//   msg_data    in  32  message content, captured in the msg_ack cycle
//   msg_ack     out  1  one-cycle accept pulse
//   msg_busy    out  1  high while a message is on display
//   page        out  2  current FSM state: 0 TIME, 1 DATE, 2 MSG
//   dsp_data    out 32  registered word to the scanner (4'hA '-', 4'hF blank)
//
// Handshake (msg_req / msg_ack): the requester raises msg_req and holds
// msg_data stable until it sees msg_ack. msg_ack is high for exactly one
// cycle, and msg_data is captured in that cycle. msg_ack is combinational
// from msg_req while the block sits in TIME or DATE. The requester must drop
// msg_req in the cycle after msg_ack. If it does not, the held level counts
// as a new request, and that request is accepted after the current message.
// ----------------------------------------------------------------------------
module seg_page_sched #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TIME_SEC = 8,
  parameter int DATE_SEC = 3,
  parameter int MSG_SEC  = 2
) (
  input  logic        seg_clk,
  input  logic        seg_rst,
  input  logic [31:0] time_bcd,
  input  logic [31:0] date_bcd,
  input  logic        hold_page,
  input  logic [7:0]  blink_mask,
  input  logic        msg_req,
  input  logic [31:0] msg_data,
  output logic        msg_ack,
  output logic        msg_busy,
  output logic [1:0]  page,
  output logic [31:0] dsp_data
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);
  // Dwell limits are stored as "last count". Each *_SEC value is expected to
  // fit in the 8-bit dwell counter.
  localparam logic [7:0] TIME_LAST = 8'(TIME_SEC - 1);
  localparam logic [7:0] DATE_LAST = 8'(DATE_SEC - 1);
  localparam logic [7:0] MSG_LAST  = 8'(MSG_SEC - 1);

  typedef enum logic [1:0] {
    ST_TIME = 2'd0,
    ST_DATE = 2'd1,
    ST_MSG  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  state_t        ret_page_q, ret_page_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    dwell_q, dwell_d;
  logic [31:0]   msg_buf_q, msg_buf_d;
  logic [31:0]   dsp_q, dsp_d;
  logic          tick;
  logic          cnt_en;
  logic          ack_raw;
  logic [7:0]    limit;
  logic [31:0]   src;

  // Prescaler: free-running 0..TICK_DIV-1. tick marks its last count.
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Page FSM. Dwell is cleared on every state change. An accepted message
  // takes priority over a dwell expiry that happens in the same cycle.
  always_comb begin
    state_d    = state_q;
    ret_page_d = ret_page_q;
    msg_buf_d  = msg_buf_q;
    ack_raw    = 1'b0;
    cnt_en     = tick;
    limit      = TIME_LAST;
    case (state_q)
      ST_TIME, ST_DATE: begin
        cnt_en = tick & ~hold_page;
        limit  = (state_q == ST_TIME) ? TIME_LAST : DATE_LAST;
        if (msg_req) begin
          ack_raw    = 1'b1;
          msg_buf_d  = msg_data;
          ret_page_d = state_q;
          state_d    = ST_MSG;
        end else if (cnt_en && (dwell_q == limit)) begin
          state_d = (state_q == ST_TIME) ? ST_DATE : ST_TIME;
        end
      end
      ST_MSG: begin
        // hold_page does not apply while a message is shown.
        cnt_en = tick;
        limit  = MSG_LAST;
        if (cnt_en && (dwell_q == limit)) begin
          state_d = ret_page_q;
        end
      end
      default: begin
        state_d = ST_TIME;
      end
    endcase

    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (cnt_en) begin
      dwell_d = dwell_q + 8'd1;
    end else begin
      dwell_d = dwell_q;
    end
  end

`ifdef SEG_PAGE_BLINK_EN
  logic blink_phase_q, blink_phase_d;

  // 1 Hz square wave: toggles at mid-count and at the wrap.
  always_comb begin
    blink_phase_d = blink_phase_q;
    if ((presc_q == PRESC_HALF) || tick) begin
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge seg_clk or posedge seg_rst) begin
    if (seg_rst) begin
      blink_phase_q <= 1'b1;
    end else begin
      blink_phase_q <= blink_phase_d;
    end
  end
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
`endif

  // Display source follows the registered state, so dsp_data lags a state
  // change or an input change by one cycle.
  always_comb begin
    case (state_q)
      ST_DATE: src = date_bcd;
      ST_MSG:  src = msg_buf_q;
      default: src = time_bcd;
    endcase
    dsp_d = src;
`ifdef SEG_PAGE_BLINK_EN
    if ((state_q != ST_MSG) && !blink_phase_q) begin
      for (int i = 0; i < 8; i++) begin
        if (blink_mask[i]) begin
          dsp_d[4*i +: 4] = 4'hF;
        end
      end
    end
`endif
  end

  always_ff @(posedge seg_clk or posedge seg_rst) begin
    if (seg_rst) begin
      state_q    <= ST_TIME;
      ret_page_q <= ST_TIME;
      presc_q    <= '0;
      dwell_q    <= '0;
      msg_buf_q  <= '0;
      dsp_q      <= 32'hFFFF_FFFF;
    end else begin
      state_q    <= state_d;
      ret_page_q <= ret_page_d;
      presc_q    <= presc_d;
      dwell_q    <= dwell_d;
      msg_buf_q  <= msg_buf_d;
      dsp_q      <= dsp_d;
    end
  end

  // Reset forces state_q to TIME, which would otherwise let a held msg_req
  // show through as an ack while reset is asserted.
  assign msg_ack  = ack_raw & ~seg_rst;
  assign msg_busy = (state_q == ST_MSG);
  assign page     = state_q;
  assign dsp_data = dsp_q;

endmodule
